// File: rtl/board_double_buffer_pkg.sv
// Shared constants and types for the ping-pong board store.
// The optional power-on scrub is enabled by defining BOARD_SCRUB_EN.
package board_double_buffer_pkg;

    localparam int WORD_SIZE     = 16;
    localparam int LOG_WORD_SIZE = 4;
    localparam int LOG_MAX_ADDR  = 12;
    localparam int MAX_ADDR      = 4096;

    typedef logic [WORD_SIZE-1:0]    word_t;
    typedef logic [LOG_MAX_ADDR-1:0] addr_t;

    typedef enum logic [1:0] {
        ST_KICK    = 2'd0,
        ST_RUN     = 2'd1,
        ST_PENDING = 2'd2,
        ST_SCRUB   = 2'd3
    } state_t;

endpackage

// File: rtl/board_double_buffer_if.sv
// Signal bundle between life_logic/display and the board store.
// The store has no valid/ready handshakes. swap_req_in and start_out are one-cycle pulses, reads return data one cycle after the address, and a write is taken on any edge with logic_wr_en_in high.
interface board_double_buffer_if;
    import board_double_buffer_pkg::*;

    logic   swap_req_in;
    logic   vblank_in;
    addr_t  logic_addr_r_in;
    word_t  logic_data_r_out;
    addr_t  logic_addr_w_in;
    word_t  logic_data_w_in;
    logic   logic_wr_en_in;
    addr_t  disp_addr_in;
    word_t  disp_data_out;
    logic   start_out;
    logic   bank_sel_out;
    logic   swap_pending_out;
    logic   overrun_out;
    state_t state_out;

    modport master (
        output swap_req_in, vblank_in, logic_addr_r_in, logic_addr_w_in,
               logic_data_w_in, logic_wr_en_in, disp_addr_in,
        input  logic_data_r_out, disp_data_out, start_out, bank_sel_out,
               swap_pending_out, overrun_out, state_out
    );

    modport slave (
        input  swap_req_in, vblank_in, logic_addr_r_in, logic_addr_w_in,
               logic_data_w_in, logic_wr_en_in, disp_addr_in,
        output logic_data_r_out, disp_data_out, start_out, bank_sel_out,
               swap_pending_out, overrun_out, state_out
    );

endinterface

// File: rtl/board_double_buffer_bank.sv
// One board bank: a single synchronous write port and two independent
// synchronous read ports. Contents are deliberately not reset.
module board_bank
    import board_double_buffer_pkg::*;
(
    input  logic  clk_in,
    input  logic  wr_en,
    input  addr_t wr_addr,
    input  word_t wr_data,
    input  addr_t rd_addr_a,
    output word_t rd_data_a,
    input  addr_t rd_addr_b,
    output word_t rd_data_b
);

    word_t mem [MAX_ADDR];

    always_ff @(posedge clk_in) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        rd_data_a <= mem[rd_addr_a];
        rd_data_b <= mem[rd_addr_b];
    end

endmodule

// File: rtl/board_double_buffer.sv
// Ping-pong board store: front bank is read, back bank is written, and the
// banks swap in vertical blank. Define BOARD_SCRUB_EN to zero both banks after reset.
module board_double_buffer
    import board_double_buffer_pkg::*;
(
    input  logic                  clk_in,
    input  logic                  rst_n_in,
    board_double_buffer_if.slave  bus
);

    state_t state_q, state_d;
    logic   bank_sel_q, bank_sel_d;
    logic   start_q, start_d;
    logic   overrun_q, overrun_d;
    logic   rd_sel_q, out_en_q;
    logic   scrubbing, scrub_last;
    addr_t  scrub_cnt;
    logic   wr_en0, wr_en1;
    addr_t  wr_addr;
    word_t  wr_data;
    word_t  disp0, disp1, logic0, logic1;

`ifdef BOARD_SCRUB_EN
    localparam state_t RESET_STATE = ST_SCRUB;
    addr_t scrub_cnt_q;

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            scrub_cnt_q <= '0;
        end else if (state_q == ST_SCRUB) begin
            scrub_cnt_q <= scrub_cnt_q + 1'b1;
        end
    end

    assign scrub_cnt  = scrub_cnt_q;
    assign scrubbing  = (state_q == ST_SCRUB);
    assign scrub_last = (scrub_cnt_q == addr_t'(MAX_ADDR - 1));
`else
    localparam state_t RESET_STATE = ST_KICK;
    assign scrub_cnt  = '0;
    assign scrubbing  = 1'b0;
    assign scrub_last = 1'b0;
`endif

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_q    <= RESET_STATE;
            bank_sel_q <= 1'b0;
            start_q    <= 1'b0;
            overrun_q  <= 1'b0;
            rd_sel_q   <= 1'b0;
            out_en_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            bank_sel_q <= bank_sel_d;
            start_q    <= start_d;
            overrun_q  <= overrun_d;
            rd_sel_q   <= bank_sel_q;
            out_en_q   <= !scrubbing;
        end
    end

    // start is registered off KICK so it lands one cycle after bank_sel toggles.
    always_comb begin
        state_d    = state_q;
        bank_sel_d = bank_sel_q;
        start_d    = 1'b0;
        overrun_d  = overrun_q;
        case (state_q)
            ST_SCRUB: begin
                if (scrub_last) begin
                    state_d = ST_KICK;
                end
            end
            ST_KICK: begin
                start_d = 1'b1;
                state_d = ST_RUN;
                if (bus.swap_req_in) begin
                    overrun_d = 1'b1;
                end
            end
            ST_RUN: begin
                if (bus.swap_req_in) begin
                    if (bus.vblank_in) begin
                        bank_sel_d = !bank_sel_q;
                        state_d    = ST_KICK;
                    end else begin
                        state_d = ST_PENDING;
                    end
                end
            end
            ST_PENDING: begin
                if (bus.swap_req_in) begin
                    overrun_d = 1'b1;
                end
                if (bus.vblank_in) begin
                    bank_sel_d = !bank_sel_q;
                    state_d    = ST_KICK;
                end
            end
            default: state_d = ST_KICK;
        endcase
    end

    // bank0 is the back bank when bank_sel=1, bank1 when bank_sel=0.
    assign wr_en0  = scrubbing | (bus.logic_wr_en_in & bank_sel_q);
    assign wr_en1  = scrubbing | (bus.logic_wr_en_in & !bank_sel_q);
    assign wr_addr = scrubbing ? scrub_cnt : bus.logic_addr_w_in;
    assign wr_data = scrubbing ? '0 : bus.logic_data_w_in;

    board_bank u_bank0 (
        .clk_in    (clk_in),
        .wr_en     (wr_en0),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .rd_addr_a (bus.disp_addr_in),
        .rd_data_a (disp0),
        .rd_addr_b (bus.logic_addr_r_in),
        .rd_data_b (logic0)
    );

    board_bank u_bank1 (
        .clk_in    (clk_in),
        .wr_en     (wr_en1),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .rd_addr_a (bus.disp_addr_in),
        .rd_data_a (disp1),
        .rd_addr_b (bus.logic_addr_r_in),
        .rd_data_b (logic1)
    );

    assign bus.disp_data_out    = out_en_q ? (rd_sel_q ? disp1 : disp0) : '0;
    assign bus.logic_data_r_out = out_en_q ? (rd_sel_q ? logic1 : logic0) : '0;
    assign bus.start_out        = start_q;
    assign bus.bank_sel_out     = bank_sel_q;
    assign bus.swap_pending_out = (state_q == ST_PENDING);
    assign bus.overrun_out      = overrun_q;
    assign bus.state_out        = state_q;

endmodule

// File: tb/tb_board_double_buffer.sv
// Self-checking bench for board_double_buffer against a behavioural model
// of the swap protocol and the two banks.
module tb_board_double_buffer;
    import board_double_buffer_pkg::*;

    logic clk_in   = 1'b0;
    logic rst_n_in = 1'b1;
    always #5 clk_in = ~clk_in;

    board_double_buffer_if bus ();

    board_double_buffer dut (
        .clk_in   (clk_in),
        .rst_n_in (rst_n_in),
        .bus      (bus.slave)
    );

    int checks   = 0;
    int failures = 0;

    // Reference model: bank contents plus protocol flags.
    word_t m_mem   [2][MAX_ADDR];
    bit    m_known [2][MAX_ADDR];
    bit    m_sel, m_kick, m_pending, m_overrun, m_start;
    int    m_scrub;
    word_t m_disp, m_logic;
    bit    m_disp_known, m_logic_known;

    function automatic void model_reset();
        m_sel = 0; m_pending = 0; m_overrun = 0; m_start = 0;
        m_disp = '0; m_logic = '0; m_disp_known = 1; m_logic_known = 1;
`ifdef BOARD_SCRUB_EN
        m_scrub = MAX_ADDR; m_kick = 0;
`else
        m_scrub = 0; m_kick = 1;
`endif
    endfunction

    function automatic void model_edge();
        bit back;
        if (m_scrub > 0) begin
            m_disp = '0; m_logic = '0; m_disp_known = 1; m_logic_known = 1;
            m_start = 0;
            m_scrub--;
            if (m_scrub == 0) begin
                m_kick = 1;
                for (int b = 0; b < 2; b++)
                    for (int a = 0; a < MAX_ADDR; a++) begin
                        m_mem[b][a] = '0; m_known[b][a] = 1;
                    end
            end
            return;
        end
        m_disp        = m_mem[m_sel][bus.disp_addr_in];
        m_disp_known  = m_known[m_sel][bus.disp_addr_in];
        m_logic       = m_mem[m_sel][bus.logic_addr_r_in];
        m_logic_known = m_known[m_sel][bus.logic_addr_r_in];
        back = m_sel ^ 1'b1;
        if (bus.logic_wr_en_in) begin
            m_mem[back][bus.logic_addr_w_in]   = bus.logic_data_w_in;
            m_known[back][bus.logic_addr_w_in] = 1;
        end
        m_start = m_kick;
        if (m_kick) begin
            m_kick = 0;
            if (bus.swap_req_in) m_overrun = 1;
        end else if (m_pending) begin
            if (bus.swap_req_in) m_overrun = 1;
            if (bus.vblank_in) begin
                m_sel = m_sel ^ 1'b1; m_pending = 0; m_kick = 1;
            end
        end else if (bus.swap_req_in) begin
            if (bus.vblank_in) begin
                m_sel = m_sel ^ 1'b1; m_kick = 1;
            end else begin
                m_pending = 1;
            end
        end
    endfunction

    task automatic tick();
        @(posedge clk_in);
        if (!rst_n_in) model_reset();
        else model_edge();
        #1;
    endtask

    task automatic drive_idle();
        bus.swap_req_in     = 1'b0;
        bus.vblank_in       = 1'b0;
        bus.logic_addr_r_in = '0;
        bus.logic_addr_w_in = '0;
        bus.logic_data_w_in = '0;
        bus.logic_wr_en_in  = 1'b0;
        bus.disp_addr_in    = '0;
    endtask

    task automatic test_reset();
        int lat;
        int exp_lat;
        bit quiet;
        drive_idle();
        #2 rst_n_in = 1'b0;
        #1 model_reset();
        checks++;
        if ({bus.bank_sel_out, bus.start_out, bus.swap_pending_out, bus.overrun_out,
             bus.disp_data_out, bus.logic_data_r_out} !== '0) begin
            failures++;
            $display("FAIL reset_outputs: sel=%b start=%b pend=%b ovr=%b disp=%h logic=%h expected all 0",
                     bus.bank_sel_out, bus.start_out, bus.swap_pending_out, bus.overrun_out,
                     bus.disp_data_out, bus.logic_data_r_out);
        end
        tick(); tick();
        rst_n_in = 1'b1;
`ifdef BOARD_SCRUB_EN
        exp_lat = MAX_ADDR + 1;
`else
        exp_lat = 1;
`endif
        lat = 1; quiet = 1;
        tick();
        while (!m_start && lat < MAX_ADDR + 10) begin
            if (bus.start_out !== 1'b0) quiet = 0;
            tick(); lat++;
        end
        checks++;
        if (!quiet || lat != exp_lat) begin
            failures++;
            $display("FAIL reset_start_latency: quiet=%0d latency=%0d expected quiet=1 latency=%0d", quiet, lat, exp_lat);
        end
        checks++;
        if (bus.start_out !== 1'b1 || bus.bank_sel_out !== 1'b0) begin
            failures++;
            $display("FAIL reset_first_start: start=%b sel=%b expected start=1 sel=0", bus.start_out, bus.bank_sel_out);
        end
        tick();
        checks++;
        if (bus.start_out !== 1'b0) begin
            failures++;
            $display("FAIL reset_start_width: start=%b expected 0", bus.start_out);
        end
    endtask

    task automatic test_swap_vblank();
        bus.logic_wr_en_in = 1; bus.logic_addr_w_in = 7; bus.logic_data_w_in = 16'hA5A5;
        tick();
        drive_idle();
        bus.swap_req_in = 1; bus.vblank_in = 1;
        tick();
        drive_idle();
        checks++;
        if (bus.bank_sel_out !== 1'b1 || bus.start_out !== 1'b0) begin
            failures++;
            $display("FAIL swap_bank_sel: sel=%b start=%b expected sel=1 start=0", bus.bank_sel_out, bus.start_out);
        end
        tick();
        checks++;
        if (bus.start_out !== 1'b1) begin
            failures++;
            $display("FAIL swap_start: start=%b expected 1", bus.start_out);
        end
        bus.disp_addr_in = 7; bus.logic_addr_r_in = 7;
        tick();
        checks++;
        if (bus.disp_data_out !== 16'hA5A5 || bus.logic_data_r_out !== 16'hA5A5) begin
            failures++;
            $display("FAIL swap_read_back: disp=%h logic=%h expected a5a5", bus.disp_data_out, bus.logic_data_r_out);
        end
    endtask

    task automatic test_pending();
        bit old_sel;
        bit stable;
        drive_idle();
        old_sel = m_sel;
        bus.swap_req_in = 1;
        tick();
        bus.swap_req_in = 0;
        checks++;
        if (bus.swap_pending_out !== 1'b1) begin
            failures++;
            $display("FAIL pending_set: pend=%b expected 1", bus.swap_pending_out);
        end
        stable = 1;
        repeat (100) begin
            tick();
            if (bus.bank_sel_out !== old_sel || bus.swap_pending_out !== 1'b1 || bus.start_out !== 1'b0)
                stable = 0;
        end
        checks++;
        if (!stable) begin
            failures++;
            $display("FAIL pending_hold: stable=%0d expected 1", stable);
        end
        bus.vblank_in = 1;
        tick();
        bus.vblank_in = 0;
        checks++;
        if (bus.bank_sel_out !== !old_sel || bus.swap_pending_out !== 1'b0) begin
            failures++;
            $display("FAIL pending_swap: sel=%b pend=%b expected sel=%b pend=0", bus.bank_sel_out, bus.swap_pending_out, !old_sel);
        end
        tick();
        checks++;
        if (bus.start_out !== 1'b1) begin
            failures++;
            $display("FAIL pending_start: start=%b expected 1", bus.start_out);
        end
    endtask

    task automatic test_overrun();
        drive_idle();
        bus.swap_req_in = 1;
        tick();
        tick();
        bus.swap_req_in = 0;
        checks++;
        if (bus.overrun_out !== 1'b1 || bus.swap_pending_out !== 1'b1) begin
            failures++;
            $display("FAIL overrun_set: ovr=%b pend=%b expected 1 1", bus.overrun_out, bus.swap_pending_out);
        end
        bus.vblank_in = 1;
        tick();
        bus.vblank_in = 0;
        repeat (5) tick();
        checks++;
        if (bus.overrun_out !== 1'b1 || bus.bank_sel_out !== m_sel) begin
            failures++;
            $display("FAIL overrun_sticky: ovr=%b sel=%b expected ovr=1 sel=%b", bus.overrun_out, bus.bank_sel_out, m_sel);
        end
    endtask

    task automatic test_same_edge_write();
        drive_idle();
        tick();
        bus.logic_wr_en_in = 1; bus.logic_addr_w_in = 3; bus.logic_data_w_in = 16'h1234;
        bus.swap_req_in = 1; bus.vblank_in = 1;
        tick();
        drive_idle();
        tick();
        bus.disp_addr_in = 3; bus.logic_addr_r_in = 3;
        tick();
        checks++;
        if (bus.disp_data_out !== 16'h1234 || bus.logic_data_r_out !== 16'h1234) begin
            failures++;
            $display("FAIL same_edge_write: disp=%h logic=%h expected 1234", bus.disp_data_out, bus.logic_data_r_out);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 600; i++) begin
            bus.swap_req_in     = ($urandom_range(0, 15) == 0);
            bus.vblank_in       = ($urandom_range(0, 3) == 0);
            bus.logic_wr_en_in  = $urandom_range(0, 1);
            bus.logic_addr_w_in = addr_t'($urandom_range(0, 31));
            bus.logic_data_w_in = word_t'($urandom);
            bus.logic_addr_r_in = addr_t'($urandom_range(0, 31));
            bus.disp_addr_in    = addr_t'($urandom_range(0, 31));
            if ($urandom_range(0, 299) == 0) begin
                rst_n_in = 1'b0;
                #1 model_reset();
                checks++;
                if ({bus.bank_sel_out, bus.start_out, bus.swap_pending_out, bus.overrun_out} !== 4'b0) begin
                    failures++;
                    $display("FAIL rand_reset cycle %0d: flags=%b expected 0000", i,
                             {bus.bank_sel_out, bus.start_out, bus.swap_pending_out, bus.overrun_out});
                end
                #1 rst_n_in = 1'b1;
            end
            tick();
            checks++;
            if ({bus.bank_sel_out, bus.start_out, bus.swap_pending_out, bus.overrun_out} !==
                {m_sel, m_start, m_pending, m_overrun}) begin
                failures++;
                $display("FAIL rand_ctrl cycle %0d: sel/start/pend/ovr=%b expected %b", i,
                         {bus.bank_sel_out, bus.start_out, bus.swap_pending_out, bus.overrun_out},
                         {m_sel, m_start, m_pending, m_overrun});
            end
            if (m_disp_known) begin
                checks++;
                if (bus.disp_data_out !== m_disp) begin
                    failures++;
                    $display("FAIL rand_disp cycle %0d: got %h expected %h", i, bus.disp_data_out, m_disp);
                end
            end
            if (m_logic_known) begin
                checks++;
                if (bus.logic_data_r_out !== m_logic) begin
                    failures++;
                    $display("FAIL rand_logic cycle %0d: got %h expected %h", i, bus.logic_data_r_out, m_logic);
                end
            end
        end
        drive_idle();
    endtask

    task automatic test_final_reset();
        drive_idle();
        bus.swap_req_in = 1;
        tick();
        tick();
        bus.swap_req_in = 0;
        #2 rst_n_in = 1'b0;
        #1 model_reset();
        checks++;
        if (bus.overrun_out !== 1'b0 || bus.swap_pending_out !== 1'b0 || bus.bank_sel_out !== 1'b0) begin
            failures++;
            $display("FAIL final_reset: ovr=%b pend=%b sel=%b expected 0 0 0",
                     bus.overrun_out, bus.swap_pending_out, bus.bank_sel_out);
        end
        tick();
        rst_n_in = 1'b1;
        tick();
    endtask

    initial begin
        drive_idle();
        test_reset();
        test_swap_vblank();
        test_pending();
        test_overrun();
        test_same_edge_write();
        test_random();
        test_final_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/board_double_buffer.md
Name: board_double_buffer

Overview:
- Ping-pong board store between life_logic and the display path.
- Two banks of MAX_ADDR words each:
  - front bank holds the current generation; display and life_logic read it;
  - back bank receives life_logic's next-state writes.
- On a generation-done pulse, the swap is deferred to the display's vertical blank. The banks then exchange roles and the next generation is kicked off with a start pulse.

Parameters:
- WORD_SIZE, 16, bits per board word.
- LOG_MAX_ADDR, 12, address width.
- MAX_ADDR, 4096, words per bank (board cells / WORD_SIZE).

Ports:
- clk_in  in  1  system clock
- rst_n_in  in  1  asynchronous active-low reset
- swap_req_in  in  1  one-cycle pulse: generation complete (life_logic done_out rising)
- vblank_in  in  1  high while the display is not reading the board
- logic_addr_r_in  in  LOG_MAX_ADDR  life_logic read address (front bank)
- logic_data_r_out  out  WORD_SIZE  front-bank word, 1-cycle latency
- logic_addr_w_in  in  LOG_MAX_ADDR  life_logic write address (back bank)
- logic_data_w_in  in  WORD_SIZE  write data
- logic_wr_en_in  in  1  write strobe
- disp_addr_in  in  LOG_MAX_ADDR  display read address (front bank)
- disp_data_out  out  WORD_SIZE  front-bank word, 1-cycle latency
- start_out  out  1  one-cycle pulse to life_logic start_in
- bank_sel_out  out  1  index of the current front bank
- swap_pending_out  out  1  swap requested, waiting for vblank
- overrun_out  out  1  sticky: swap_req_in arrived while a swap was already pending

Behaviour:
- Reset (async, any time, including mid-scrub or mid-pending):
  - bank_sel_out=0, start_out=0, swap_pending_out=0, overrun_out=0;
  - both data outputs 0;
  - FSM goes to KICK (or SCRUB if the optional feature is enabled).
  - Memory contents are not reset.
- Reads:
  - Both read ports are synchronous and fully independent.
  - data_out(t+1) = front[addr(t)], where front is the bank selected at cycle t.
  - No arbitration: each bank is built with 1 write port and 2 read ports.
- Writes:
  - When logic_wr_en_in=1 at edge t, the back bank (!bank_sel at t) is written.
  - Write and swap on the same edge: the write lands in the pre-swap back bank, which becomes front.
  - Same-address read of the back bank is never possible, because reads target the front bank only.
- FSM:
  - KICK: start_out=1 for exactly one cycle -> RUN.
  - RUN:
    - swap_req_in && vblank_in -> toggle bank_sel, go to KICK;
    - swap_req_in && !vblank_in -> PENDING, swap_pending_out=1.
  - PENDING:
    - vblank_in -> toggle bank_sel, swap_pending_out=0, go to KICK;
    - swap_req_in while in PENDING -> overrun_out=1 (sticky until reset), request absorbed.
  - swap_req_in while in KICK: treated as overrun, ignored.
- Timing:
  - start_out asserts the cycle after bank_sel_out toggles, so life_logic never fetches from the old front.
  - Minimum swap_req-to-start latency is 2 cycles.
- vblank_in is sampled as a level; no edge detection.

Optional Feature:
- BOARD_SCRUB_EN defined:
  - After reset the FSM enters SCRUB.
  - A counter sweeps addresses 0..MAX_ADDR-1, writing 0 to both banks (MAX_ADDR cycles).
  - logic_wr_en_in is ignored during SCRUB; read outputs return 0.
  - swap_req_in is ignored during SCRUB.
  - On reaching the last address -> KICK.
- Not defined:
  - No SCRUB state; reset goes straight to KICK.
  - Initial contents are whatever memory init provides.

Decomposition:
- Shared package (common.svh): WORD_SIZE, LOG_WORD_SIZE, LOG_MAX_ADDR, MAX_ADDR, and a word_t typedef.
- One sub-module, board_bank: 1 synchronous write port, 2 synchronous read ports, instantiated twice.
- Bank-select muxing and the FSM stay in the top level.

Test Plan:
- Reset release, scrub off -> start_out high exactly cycle 1 after reset release, for 1 cycle; bank_sel_out=0.
- Write 0xA5A5 to addr 7 (back=bank1), pulse swap_req with vblank=1:
  - bank_sel_out=1 next cycle, start_out 1 cycle later;
  - disp_addr=7 and logic_addr_r=7 both return 0xA5A5 one cycle after their addresses are applied.
- swap_req with vblank=0:
  - swap_pending_out=1, bank_sel unchanged for 100 cycles;
  - vblank rises -> bank toggles next edge, start_out pulses after it.
- Second swap_req during PENDING -> overrun_out=1 and stays 1 through the subsequent swap; cleared only by rst_n_in.
- Write addr 3 on the same edge as the swap -> new front reads 0x1234 at addr 3.
- BOARD_SCRUB_EN:
  - preload banks with 0xFFFF, reset -> no start_out for MAX_ADDR cycles;
  - then start_out pulses; every address in both banks reads 0.
  - Assert reset mid-scrub -> scrub restarts from addr 0.
